// File: rtl/bfly_sel_gen.sv
// Butterfly coefficient-address and bank-select generator: issues one beat per cycle
// of per-lane addresses, their banks, the bank-to-lane gather map and a conflict flag.
module bfly_sel_gen #(
    parameter int P    = 2,
    parameter int SELW = $clog2(2 * P),
    parameter int AW   = 8,
    parameter int STW  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [STW-1:0]        num_stages,
    output logic                  busy,
    output logic                  done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [STW-1:0]        out_stage,
    output logic [AW-1:0]         out_cnt,
    output logic [2*P*AW-1:0]     addr_bus,
    output logic [2*P*SELW-1:0]   sel_in_bus,
    output logic [2*P*SELW-1:0]   sel_out_bus,
    output logic                  conflict
);
    localparam int N    = 2 * P;
    localparam int NDIG = (AW + SELW - 1) / SELW;
    localparam logic [AW-1:0] CMAX = AW'((1 << (AW - 1)) / P - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                    state_q, state_d;
    logic [STW-1:0]            s_q, s_d, nstg_q, nstg_d;
    logic [AW-1:0]             cnt_q, cnt_d;
    logic                      done_q, done_d;

    logic                      v1_q, v1_d, last1_q, last1_d;
    logic [STW-1:0]            stg1_q, stg1_d;
    logic [AW-1:0]             cnt1_q, cnt1_d;
    logic [N-1:0][AW-1:0]      addr1_q, addr1_d;
    logic [N-1:0][SELW-1:0]    bank1_q, bank1_d;

    logic                      v2_q, v2_d, last2_q, last2_d;
    logic [STW-1:0]            stg2_q, stg2_d;
    logic [AW-1:0]             cnt2_q, cnt2_d;
    logic [N-1:0][AW-1:0]      addr2_q, addr2_d;
    logic [N-1:0][SELW-1:0]    bank2_q, bank2_d;
    logic [N-1:0][SELW-1:0]    selo2_q, selo2_d;
    logic                      conf2_q, conf2_d;

    logic [N-1:0][AW-1:0]      addr_w;
    logic [N-1:0][SELW-1:0]    bank_w;
    logic [N-1:0][SELW-1:0]    selo_w;
    logic                      conf_w;

    logic                      stall, issue, last_beat, accept_last;
    logic [STW-1:0]            nclip;

    assign stall       = v2_q && !out_ready;
    assign issue       = (state_q == RUN) && !stall;
    assign last_beat   = (s_q == nstg_q - STW'(1)) && (cnt_q == CMAX);
    assign accept_last = v2_q && out_ready && last2_q;
    assign nclip       = (num_stages > STW'(AW)) ? STW'(AW) : num_stages;

    // Lane address: insert a zero at bit s of the butterfly index, odd lanes take the +h partner.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [AW-1:0]        b_w, h_w, base_w;
        logic [NDIG*SELW-1:0] pad_w;
        logic [SELW-1:0]      sum_w;

        assign b_w    = AW'(32'(cnt_q) * P + gi / 2);
        assign h_w    = AW'(1) << s_q;
        assign base_w = ((b_w >> s_q) << (s_q + STW'(1))) | (b_w & (h_w - AW'(1)));

        if (gi % 2 == 1) begin : g_odd
            assign addr_w[gi] = base_w | h_w;
        end else begin : g_even
            assign addr_w[gi] = base_w;
        end

        always_comb begin
            pad_w          = '0;
            pad_w[AW-1:0]  = addr_w[gi];
            sum_w          = '0;
            for (int d = 0; d < NDIG; d++) begin
                sum_w = sum_w + pad_w[d*SELW +: SELW];
            end
        end
        assign bank_w[gi] = sum_w;
    end

    // Gather map: an empty bank's marker value N does not fit in SELW bits and reads as 0.
    for (genvar gi = 0; gi < N; gi++) begin : g_bank
        logic [SELW-1:0] sel_w;
        always_comb begin
            sel_w = SELW'(N);
            for (int j = N - 1; j >= 0; j--) begin
                if (bank1_q[j] == SELW'(gi)) begin
                    sel_w = SELW'(j);
                end
            end
        end
        assign selo_w[gi] = sel_w;
    end

    always_comb begin
        conf_w = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = i + 1; j < N; j++) begin
                if (bank1_q[i] == bank1_q[j]) begin
                    conf_w = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        nstg_d  = nstg_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (nclip == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        s_d     = '0;
                        cnt_d   = '0;
                        nstg_d  = nclip;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    if (cnt_q == CMAX) begin
                        cnt_d = '0;
                        s_d   = s_q + STW'(1);
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                    if (last_beat) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (accept_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Both pipeline stages advance together; a stall freezes everything.
    always_comb begin
        v1_d    = v1_q;
        last1_d = last1_q;
        stg1_d  = stg1_q;
        cnt1_d  = cnt1_q;
        addr1_d = addr1_q;
        bank1_d = bank1_q;
        v2_d    = v2_q;
        last2_d = last2_q;
        stg2_d  = stg2_q;
        cnt2_d  = cnt2_q;
        addr2_d = addr2_q;
        bank2_d = bank2_q;
        selo2_d = selo2_q;
        conf2_d = conf2_q;
        if (!stall) begin
            v1_d    = issue;
            last1_d = issue && last_beat;
            if (issue) begin
                stg1_d  = s_q;
                cnt1_d  = cnt_q;
                addr1_d = addr_w;
                bank1_d = bank_w;
            end
            v2_d    = v1_q;
            last2_d = last1_q;
            if (v1_q) begin
                stg2_d  = stg1_q;
                cnt2_d  = cnt1_q;
                addr2_d = addr1_q;
                bank2_d = bank1_q;
                selo2_d = selo_w;
                conf2_d = conf_w;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            cnt_q   <= '0;
            nstg_q  <= '0;
            done_q  <= 1'b0;
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            stg1_q  <= '0;
            cnt1_q  <= '0;
            addr1_q <= '0;
            bank1_q <= '0;
            v2_q    <= 1'b0;
            last2_q <= 1'b0;
            stg2_q  <= '0;
            cnt2_q  <= '0;
            addr2_q <= '0;
            bank2_q <= '0;
            selo2_q <= '0;
            conf2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            nstg_q  <= nstg_d;
            done_q  <= done_d;
            v1_q    <= v1_d;
            last1_q <= last1_d;
            stg1_q  <= stg1_d;
            cnt1_q  <= cnt1_d;
            addr1_q <= addr1_d;
            bank1_q <= bank1_d;
            v2_q    <= v2_d;
            last2_q <= last2_d;
            stg2_q  <= stg2_d;
            cnt2_q  <= cnt2_d;
            addr2_q <= addr2_d;
            bank2_q <= bank2_d;
            selo2_q <= selo2_d;
            conf2_q <= conf2_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign out_valid   = v2_q;
    assign out_stage   = stg2_q;
    assign out_cnt     = cnt2_q;
    assign addr_bus    = addr2_q;
    assign sel_in_bus  = bank2_q;
    assign sel_out_bus = selo2_q;
    assign conflict    = conf2_q;

endmodule

// File: tb/tb_bfly_sel_gen.sv
// Bench for bfly_sel_gen (P=2, AW=4): directed and random sequences scored against an
// arithmetic model of the butterfly address/bank rules.
module tb_bfly_sel_gen;
    localparam int P    = 2;
    localparam int N    = 2 * P;
    localparam int SELW = 2;
    localparam int AW   = 4;
    localparam int STW  = 4;
    localparam int C    = (1 << (AW - 1)) / P;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                start = 1'b0;
    logic [STW-1:0]      num_stages = '0;
    logic                out_ready = 1'b1;
    logic                busy, done, out_valid, conflict;
    logic [STW-1:0]      out_stage;
    logic [AW-1:0]       out_cnt;
    logic [N*AW-1:0]     addr_bus;
    logic [N*SELW-1:0]   sel_in_bus, sel_out_bus;

    int checks = 0;
    int errors = 0;
    int last_beats;

    typedef struct {
        logic [STW-1:0]    stg;
        logic [AW-1:0]     cnt;
        logic [N*AW-1:0]   addr;
        logic [N*SELW-1:0] si;
        logic [N*SELW-1:0] so;
        logic              conf;
    } beat_t;

    beat_t q[$];
    logic [N*AW-1:0]   cap_addr[64];
    logic [N*SELW-1:0] cap_si[64];
    logic [N*SELW-1:0] cap_so[64];
    logic              cap_conf[64];

    bfly_sel_gen #(.P(P), .SELW(SELW), .AW(AW), .STW(STW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_stages(num_stages),
        .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
        .out_stage(out_stage), .out_cnt(out_cnt), .addr_bus(addr_bus),
        .sel_in_bus(sel_in_bus), .sel_out_bus(sel_out_bus), .conflict(conflict)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_addr(int s, int cnt, int j);
        int b = cnt * P + j / 2;
        int h = 1 << s;
        return (b / h) * 2 * h + (b % h) + (j % 2) * h;
    endfunction

    function automatic int ref_bank(int a);
        int sum = 0;
        int v = a;
        while (v > 0) begin
            sum += v % N;
            v = v / N;
        end
        return sum % N;
    endfunction

    function automatic beat_t ref_beat(int s, int cnt);
        beat_t bt;
        int bank[N];
        int hits[N];
        int owner;
        bt.stg  = STW'(s);
        bt.cnt  = AW'(cnt);
        bt.addr = '0;
        bt.si   = '0;
        bt.so   = '0;
        bt.conf = 1'b0;
        for (int k = 0; k < N; k++) hits[k] = 0;
        for (int j = 0; j < N; j++) begin
            int a = ref_addr(s, cnt, j);
            bank[j] = ref_bank(a);
            bt.addr[j*AW +: AW]   = AW'(a);
            bt.si[j*SELW +: SELW] = SELW'(bank[j]);
            hits[bank[j]]++;
        end
        for (int k = 0; k < N; k++) begin
            owner = N;  // empty bank: value N, truncated to SELW bits on the bus
            for (int j = N - 1; j >= 0; j--) if (bank[j] == k) owner = j;
            bt.so[k*SELW +: SELW] = SELW'(owner);
            if (hits[k] > 1) bt.conf = 1'b1;
        end
        return bt;
    endfunction

    // mode 0: always ready; 1: random ready; 2: ready low for three cycles mid-run
    task automatic run_seq(input int ns, input int mode);
        int    s_run = (ns > AW) ? AW : ns;
        int    c = 0;
        bit    exp_done, prev_stall, first_seen, acc, rdy;
        beat_t cur;
        q.delete();
        for (int s = 0; s < s_run; s++)
            for (int k = 0; k < C; k++) q.push_back(ref_beat(s, k));
        last_beats = 0;
        start      = 1'b1;
        num_stages = STW'(ns);
        @(posedge clk); #1;
        start      = 1'b0;
        exp_done   = (q.size() == 0);
        prev_stall = 1'b0;
        first_seen = 1'b0;
        while (1) begin
            chk("done", done, exp_done);
            chk("busy", busy, q.size() != 0);
            if (prev_stall) chk("hold_valid", out_valid, 1);
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("extra_beat", out_valid, 0);
                end else begin
                    cur = q[0];
                    chk("stage", out_stage, cur.stg);
                    chk("cnt", out_cnt, cur.cnt);
                    chk("addr", addr_bus, cur.addr);
                    chk("sel_in", sel_in_bus, cur.si);
                    chk("sel_out", sel_out_bus, cur.so);
                    chk("conflict", conflict, cur.conf);
                    if (!first_seen) chk("latency", c, 2);
                    first_seen = 1'b1;
                end
            end
            if (exp_done) break;
            if (c >= 300) begin
                chk("timeout_beats_left", q.size(), 0);
                break;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 9) < 6);
                default: rdy = !(c >= 6 && c <= 8);
            endcase
            out_ready = rdy;
            if (c == 5 && q.size() >= 2) begin
                start      = 1'b1;  // must be ignored while busy
                num_stages = STW'($urandom_range(0, 15));
            end
            acc        = out_valid && rdy && (q.size() > 0);
            prev_stall = out_valid && !rdy;
            if (acc) begin
                cap_addr[out_stage*C + out_cnt] = addr_bus;
                cap_si[out_stage*C + out_cnt]   = sel_in_bus;
                cap_so[out_stage*C + out_cnt]   = sel_out_bus;
                cap_conf[out_stage*C + out_cnt] = conflict;
            end
            @(posedge clk); #1;
            start = 1'b0;
            c++;
            if (acc) begin
                void'(q.pop_front());
                last_beats++;
                if (q.size() == 0) exp_done = 1'b1;
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("done_single", done, 0);
        chk("idle_valid", out_valid, 0);
        $display("sequence num_stages=%0d mode=%0d beats=%0d cycles=%0d", ns, mode, last_beats, c);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_addr", addr_bus, 0);
        chk("rst_sel_out", sel_out_bus, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // three stages, always ready, with directed vectors for the first beats of each stage
        run_seq(3, 0);
        chk("b0_addr", cap_addr[0], 16'h3210);
        chk("b0_sel_in", cap_si[0], 8'hE4);
        chk("b0_sel_out", cap_so[0], 8'hE4);
        chk("b1_addr", cap_addr[1], 16'h7654);
        chk("b1_sel_in", cap_si[1], 8'h39);
        chk("b1_sel_out", cap_so[1], 8'h93);
        chk("s1_addr", cap_addr[C], 16'h3120);
        chk("s1_sel_in", cap_si[C], 8'hD8);
        chk("s1_sel_out", cap_so[C], 8'hD8);
        chk("s1_conflict", cap_conf[C], 0);
        chk("s2_addr", cap_addr[2*C], 16'h5140);
        chk("s2_sel_in", cap_si[2*C], 8'h94);
        chk("s2_sel_out", cap_so[2*C], 8'h34);
        chk("s2_conflict", cap_conf[2*C], 1);

        run_seq(1, 0);
        chk("beats_ns1", last_beats, 4);
        run_seq(9, 2);
        chk("beats_ns9_clipped", last_beats, 16);
        run_seq(2, 1);
        for (int i = 0; i < 4; i++) run_seq($urandom_range(1, 15), 1);

        // reset during beat 5 of a sequence
        start = 1'b1; num_stages = 4'd4; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_beat", {out_stage, out_cnt}, {4'd1, 4'd1});
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_conflict", conflict, 0);
        chk("midrst_stage_cnt", {out_stage, out_cnt}, 0);
        chk("midrst_addr", addr_bus, 0);
        chk("midrst_sel_in", sel_in_bus, 0);
        chk("midrst_sel_out", sel_out_bus, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("post_rst_no_done", done, 0);
        end

        run_seq(0, 0);
        chk("beats_ns0", last_beats, 0);
        run_seq(2, 0);
        chk("beats_fresh", last_beats, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bfly_sel_gen.md
BFLY_SEL_GEN -- requirements
Module: bfly_sel_gen

Interface
- REQ-001 Parameter P, default `P: butterfly units; lane count N = 2*P, a power of two.
- REQ-002 Parameter SELW, default `MAP: lane/bank select width, log2(N).
- REQ-003 Parameter AW, default 8: coefficient address width; transform length 2^AW.
- REQ-004 Parameter STW, default 4: stage-count width; covers 0..AW.
- REQ-005 clk  in  1  sole clock, rising edge.
- REQ-006 rst_n  in  1  reset, asynchronous, active-low.
- REQ-007 start  in  1  single-cycle request to begin a sequence.
- REQ-008 num_stages  in  STW  stages to run; values above AW are clipped to AW.
- REQ-009 busy  out  1  sequence in progress.
- REQ-010 done  out  1  one-cycle pulse after the last beat is accepted.
- REQ-011 out_valid  out  1  beat available.
- REQ-012 out_ready  in  1  consumer accepts the beat.
- REQ-013 out_stage  out  STW  stage index s of the beat.
- REQ-014 out_cnt  out  AW  beat index within the stage.
- REQ-015 addr_bus  out  N*AW  per-lane coefficient address; lane j at [j*AW +: AW].
- REQ-016 sel_in_bus  out  N*SELW  per-lane bank (scatter select); lane j at [j*SELW +: SELW].
- REQ-017 sel_out_bus  out  N*SELW  per-bank source lane (gather select); bank k at [k*SELW +: SELW].
- REQ-018 conflict  out  1  two or more lanes of the beat map to one bank.

Function
- REQ-019 FSM states: IDLE, RUN, FLUSH; IDLE->RUN on start with clipped num_stages>0; RUN->FLUSH after the last beat is issued into the pipeline; FLUSH->IDLE when the last beat is accepted at the output, asserting done that same cycle.
- REQ-020 start with num_stages=0: no beats; done pulses the following cycle; state stays IDLE.
- REQ-021 start while busy is ignored; busy = (state != IDLE).
- REQ-022 Beats per stage C = 2^(AW-1)/P; order: s = 0..S-1 outer, cnt = 0..C-1 inner; one new beat per cycle when not stalled.
- REQ-023 Lane j: pair p = j>>1, butterfly b = cnt*P + p, h = 2^s; addr = ((b>>s)<<(s+1)) | (b & (h-1)), plus h when j is odd.
- REQ-024 Bank of addr = sum of its SELW-bit digits, mod N (sum width truncated to SELW).
- REQ-025 sel_out for bank k = lowest lane j whose bank equals k; value N (out of range) when no lane maps to k.
- REQ-026 conflict = 1 iff any bank receives more than one lane.
- REQ-027 Two-stage pipeline: stage 1 registers addresses and banks; stage 2 registers sel_out and conflict; all outputs of one beat are aligned.
- REQ-028 First out_valid occurs 2 cycles after the start edge.
- REQ-029 Stall: out_valid && !out_ready freezes the counters and both pipeline stages; all outputs are held stable.
- REQ-030 A beat is transferred on out_valid && out_ready; out_valid never drops without a transfer.
- REQ-031 Stage counter increments and cnt wraps to 0 at cnt = C-1 in the same cycle.

Reset
- REQ-032 rst_n low asynchronously forces IDLE and clears busy, done, out_valid, conflict, out_stage, out_cnt and all buses to 0.
- REQ-033 Reset mid-sequence abandons it without a done pulse; the first start after reset release begins a fresh sequence from s=0, cnt=0.

Verification (P=2, N=4, SELW=2, AW=4, C=4)
- REQ-034 start with num_stages=1, out_ready=1 -> 4 beats on consecutive cycles from cycle +2; beat 0: addr {0,1,2,3}, sel_in {0,1,2,3}, sel_out {0,1,2,3}; beat 1: addr {4,5,6,7}, sel_in {1,2,3,0}, sel_out {3,0,1,2}; done 1 cycle after beat 3 is accepted.
- REQ-035 num_stages=2, s=1, cnt=0 -> addr {0,2,1,3}, sel_in {0,2,1,3}, sel_out {0,2,1,3}, conflict=0.
- REQ-036 s=2, cnt=0 -> addr {0,4,1,5}, sel_in {0,1,1,2}, sel_out {0,1,3,4}, conflict=1.
- REQ-037 out_ready low for 3 cycles mid-stage -> outputs held, no beat lost or duplicated; num_stages=9 -> clipped to 4 stages, 16 beats total.
- REQ-038 rst_n pulsed low during beat 5 -> outputs cleared immediately, no done; start with num_stages=0 -> done pulse next cycle, out_valid stays 0.
